// File: rtl/mfcc_log_pipe.sv
// mfcc_log_pipe: three-stage fixed-point log2 / ln of unsigned mel-filter energies.
// Result = k*2^FRAC_W + fraction, where k is the leading-one index of the input.
// A natural-log result is produced by scaling with ln2 in Q0.16.
// Build option: define LOG_LUT_CORR_EN to add a 16-entry piecewise correction
// to the linear log2 fraction. Latency is the same with and without it.
module mfcc_log_pipe #(
  parameter int unsigned IN_W   = 44,
  parameter int unsigned FRAC_W = 9,
  parameter int unsigned OUT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_ln,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_zero,
  output logic [15:0]      zero_cnt
);

  localparam int unsigned KW       = $clog2(IN_W);
  localparam int unsigned EW       = IN_W + FRAC_W;
  localparam int unsigned PW       = OUT_W + 16;
  localparam int unsigned LN2_Q16  = 45426;
  localparam int unsigned HALF_Q16 = 32768;

  // Reject a result width too narrow to hold the integer part, fraction and carry.
  if (OUT_W < $clog2(IN_W) + FRAC_W + 1) begin : g_bad_out_w
    $error("mfcc_log_pipe: OUT_W too small for IN_W/FRAC_W");
  end

`ifdef LOG_LUT_CORR_EN
  localparam int unsigned CSH_L = (FRAC_W >= 9) ? FRAC_W - 9 : 0;
  localparam int unsigned CSH_R = (FRAC_W < 9)  ? 9 - FRAC_W : 0;

  // Correction for log2(1+f) - f, tabulated in units of 2^-9 and rescaled to FRAC_W.
  function automatic logic [OUT_W-1:0] corr_lut(input logic [3:0] idx);
    logic [15:0] c9;
    c9 = 16'd0;
    case (idx)
      4'd0:  c9 = 16'd0;
      4'd1:  c9 = 16'd13;
      4'd2:  c9 = 16'd23;
      4'd3:  c9 = 16'd31;
      4'd4:  c9 = 16'd37;
      4'd5:  c9 = 16'd41;
      4'd6:  c9 = 16'd43;
      4'd7:  c9 = 16'd44;
      4'd8:  c9 = 16'd44;
      4'd9:  c9 = 16'd42;
      4'd10: c9 = 16'd39;
      4'd11: c9 = 16'd35;
      4'd12: c9 = 16'd29;
      4'd13: c9 = 16'd23;
      4'd14: c9 = 16'd16;
      default: c9 = 16'd9;
    endcase
    return OUT_W'((c9 << CSH_L) >> CSH_R);
  endfunction
`endif

  // Whole pipe advances together; it only holds when the output is blocked.
  assign in_ready = !out_valid || out_ready;

  logic [KW-1:0]    k_c;
  logic             s1_valid;
  logic [KW-1:0]    s1_k;
  logic             s1_zero;
  logic             s1_ln;
  logic [IN_W-1:0]  s1_data;

  logic [KW-1:0]    sh_c;
  logic [EW-1:0]    ext_c;
  logic [FRAC_W-1:0] frac_c;
  logic [OUT_W-1:0] log2v_c;
  logic             s2_valid;
  logic             s2_zero;
  logic             s2_ln;
  logic [OUT_W-1:0] s2_log2v;

  logic [PW-1:0]    prod_c;
  logic [OUT_W-1:0] ln_c;

  // Leading-one detector: highest set bit wins.
  always_comb begin
    k_c = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (in_data[i]) k_c = KW'(i);
    end
  end

  // Stage 1: capture MSB index, zero flag, mode and raw energy.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_k     <= '0;
      s1_zero  <= 1'b0;
      s1_ln    <= 1'b0;
      s1_data  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      s1_k     <= k_c;
      s1_zero  <= (in_data == '0);
      s1_ln    <= in_ln;
      s1_data  <= in_data;
    end
  end

  // Normalise so the leading one lands just above the fraction field; bits below
  // the MSB become the fraction, truncated or zero-filled as needed.
  always_comb begin
    sh_c   = KW'(IN_W - 1) - s1_k;
    ext_c  = {s1_data, {FRAC_W{1'b0}}} << sh_c;
    frac_c = FRAC_W'(ext_c >> (IN_W - 1));
`ifdef LOG_LUT_CORR_EN
    log2v_c = OUT_W'({s1_k, frac_c}) + corr_lut(frac_c[FRAC_W-1 -: 4]);
`else
    log2v_c = OUT_W'({s1_k, frac_c});
`endif
  end

  // Stage 2: register the log2 value.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_zero  <= 1'b0;
      s2_ln    <= 1'b0;
      s2_log2v <= '0;
    end else if (in_ready) begin
      s2_valid <= s1_valid;
      s2_zero  <= s1_zero;
      s2_ln    <= s1_ln;
      s2_log2v <= log2v_c;
    end
  end

  // ln(x) = log2(x) * ln2, ln2 in Q0.16, rounded half up.
  always_comb begin
    prod_c = PW'(s2_log2v) * PW'(LN2_Q16) + PW'(HALF_Q16);
    ln_c   = OUT_W'(prod_c >> 16);
  end

  // Stage 3: output register; zero inputs force a zero result with the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_zero  <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= s2_valid;
      out_zero  <= s2_zero;
      if (s2_zero)    out_data <= '0;
      else if (s2_ln) out_data <= ln_c;
      else            out_data <= s2_log2v;
    end
  end

  // Saturating count of accepted zero-energy samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_cnt <= 16'd0;
    end else if (in_valid && in_ready && (in_data == '0) && (zero_cnt != 16'hFFFF)) begin
      zero_cnt <= zero_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mfcc_log_pipe.sv
// Bench for mfcc_log_pipe: directed spot values, stall/hold, mid-flight reset and a
// random valid/ready stream, all scored against an arithmetic reference model.
// Works in both builds (LOG_LUT_CORR_EN defined or not).
module tb_mfcc_log_pipe;

  localparam int unsigned IN_W   = 44;
  localparam int unsigned FRAC_W = 9;
  localparam int unsigned OUT_W  = 16;
  localparam int unsigned N_RAND = 3000;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_ln;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_zero;
  logic [15:0]      zero_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int n_retired = 0;
  int zmodel = 0;
  logic held = 1'b0;
  logic [OUT_W:0] held_v = '0;
  logic [OUT_W:0] sb_q[$];

  mfcc_log_pipe #(.IN_W(IN_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ln(in_ln),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .zero_cnt(zero_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer-arithmetic log2 with optional correction and ln scaling.
  function automatic logic [OUT_W-1:0] ref_log(input logic [IN_W-1:0] x, input logic ln);
    int k;
    longint unsigned xv, fr, l2;
`ifdef LOG_LUT_CORR_EN
    int unsigned ctab [16] = '{0,13,23,31,37,41,43,44,44,42,39,35,29,23,16,9};
`endif
    xv = 64'(x);
    k = -1;
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (x[i] && k < 0) k = i;
    end
    if (k < 0) return '0;
    if (k >= FRAC_W) fr = (xv >> (k - FRAC_W)) & ((64'd1 << FRAC_W) - 64'd1);
    else             fr = (xv & ((64'd1 << k) - 64'd1)) << (FRAC_W - k);
    l2 = (64'(k) << FRAC_W) + fr;
`ifdef LOG_LUT_CORR_EN
    l2 = l2 + 64'(ctab[fr >> (FRAC_W - 4)]);
`endif
    if (ln) l2 = (l2 * 64'd45426 + 64'd32768) >> 16;
    return OUT_W'(l2);
  endfunction

  // Scoreboard: push on input transfer, pop on output transfer, check held outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        zmodel = 0;
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_data", 64'({out_zero, out_data}), 64'(held_v));
        end
        if (out_valid && out_ready) begin
          n_retired++;
          if (sb_q.size() == 0) check("spurious_out", 64'd1, 64'd0);
          else check("sb_data", 64'({out_zero, out_data}), 64'(sb_q.pop_front()));
        end
        held = out_valid && !out_ready;
        held_v = {out_zero, out_data};
        if (in_valid && in_ready) begin
          sb_q.push_back({(in_data == '0), ref_log(in_data, in_ln)});
          if (in_data == '0 && zmodel < 65535) zmodel++;
        end
      end
    end
  end

  // One sample into an empty pipe; result must appear on the third edge counting the accept edge.
  task automatic run_one(input logic [IN_W-1:0] d, input logic ln,
                         input logic [OUT_W-1:0] ed, input logic ez, input string tag);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_ln = ln; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd3);
    check(tag, 64'({out_zero, out_data}), 64'({ez, ed}));
  endtask

  task automatic drain(input string tag);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    check(tag, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int sent, cyc, base, seen, w;
    logic acc;
    longint unsigned r;
    logic [OUT_W-1:0] e3, e5;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ln = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_zero", 64'(out_zero), 64'd0);
    check("rst_zcnt", 64'(zero_cnt), 64'd0);
    rst = 1'b0;

`ifdef LOG_LUT_CORR_EN
    e3 = 16'h032C; e5 = 16'h04A5;
`else
    e3 = 16'h0300; e5 = 16'h0480;
`endif
    run_one(IN_W'(1), 1'b0, 16'h0000, 1'b0, "log2_1");
    run_one(IN_W'(2), 1'b0, 16'h0200, 1'b0, "log2_2");
    run_one(IN_W'(3), 1'b0, e3, 1'b0, "log2_3");
    run_one(IN_W'(64'd1 << 43), 1'b0, 16'h5600, 1'b0, "log2_2p43");
    run_one(IN_W'(2), 1'b1, 16'h0163, 1'b0, "ln_2");
    run_one(IN_W'(64'd1 << 43), 1'b1, 16'h3B9C, 1'b0, "ln_2p43");
    run_one({IN_W{1'b1}}, 1'b0, ref_log({IN_W{1'b1}}, 1'b0), 1'b0, "log2_max");
    check("zcnt_before", 64'(zero_cnt), 64'd0);
    run_one(IN_W'(0), 1'b1, 16'h0000, 1'b1, "zero_ln");
    check("zcnt_after", 64'(zero_cnt), 64'd1);
    run_one(IN_W'(5), 1'b0, e5, 1'b0, "after_zero");
    drain("drain_directed");

    // Eight-sample stream with the output blocked on cycles 4..6.
    base = n_retired;
    sent = 0; cyc = 0;
    while (sent < 8 && cyc < 60) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid = 1'b1;
      in_data = IN_W'(100 + sent * 37);
      in_ln = sent[0];
      #1;
      if (cyc >= 4 && cyc <= 6) check("stall_in_ready", 64'(in_ready), 64'd0);
      if (in_ready) sent++;
      cyc++;
    end
    drain("drain_stall");
    check("stall_count", 64'(n_retired - base), 64'd8);

    // Reset with three samples in flight: none may emerge afterwards.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = '0; in_ln = 1'b0;
    @(posedge clk); #1;
    in_data = IN_W'(7);
    @(posedge clk); #1;
    in_data = IN_W'(9);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_zcnt", 64'(zero_cnt), 64'(zmodel));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_data", 64'(out_data), 64'd0);
    check("midrst_zcnt", 64'(zero_cnt), 64'd0);
    out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_none", 64'(seen), 64'd0);

    // Random stream with random valid/ready; data held until accepted.
    sent = 0; acc = 1'b0;
    for (int c = 0; c < 30000 && sent < N_RAND; c++) begin
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 9) < 7);
        w = $urandom_range(0, IN_W);
        r = {$urandom, $urandom};
        r = (w == 0) ? 64'd0 : (r & ((64'd1 << w) - 64'd1));
        if ($urandom_range(0, 15) == 0) r = 64'd0;
        in_data = IN_W'(r);
        in_ln = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      acc = in_valid && in_ready;
      if (acc) sent++;
    end
    check("rand_sent", 64'(sent), 64'(N_RAND));
    drain("drain_rand");
    check("final_zcnt", 64'(zero_cnt), 64'(zmodel));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
